// File: rtl/h3_encode_stream_n_k_pkg.sv
// Shared Hamming SEC definitions: legal (n,k) pairs, data-to-position map and parity masks.
// The same masks define the syndrome bits computed by the downstream corrector.
package h3_encode_stream_n_k_pkg;

  localparam int unsigned MaxN = 15;
  localparam int unsigned MaxR = 4;

  // Bit i of each mask is Hamming position i+1; mask j selects positions with bit j set.
  localparam logic [MaxN-1:0] PMask0 = 15'h5555;
  localparam logic [MaxN-1:0] PMask1 = 15'h6666;
  localparam logic [MaxN-1:0] PMask2 = 15'h7878;
  localparam logic [MaxN-1:0] PMask3 = 15'h7F80;

  function automatic bit legal_nk(input int unsigned n, input int unsigned k);
    return ((n == 15) && (k == 11)) || ((n == 7) && (k == 4));
  endfunction

  function automatic logic [MaxN-1:0] parity_mask(input int unsigned j);
    logic [MaxN-1:0] mask;
    mask = '0;
    unique case (j)
      0: mask = PMask0;
      1: mask = PMask1;
      2: mask = PMask2;
      3: mask = PMask3;
      default: mask = '0;
    endcase
    return mask;
  endfunction

  // 1-based codeword position of data bit idx: the idx-th non-power-of-two position.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 1; p <= MaxN; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/h3_encode_n_k.sv
// Purely combinational (n,k) Hamming SEC encoder; parity sits at positions 2^j.
module h3_encode_n_k
  import h3_encode_stream_n_k_pkg::*;
#(
  parameter int unsigned n = 15,
  parameter int unsigned k = 11
) (
  input  logic [k-1:0] data_i,
  output logic [n-1:0] code_o
);

  localparam int unsigned R = n - k;

  logic [n-1:0]    w_place;
  logic [MaxN-1:0] w_mask;

  always_comb begin
    w_place = '0;
    w_mask  = '0;
    for (int unsigned i = 0; i < k; i++) begin
      w_place[data_pos(i) - 1] = data_i[i];
    end
    code_o = w_place;
    // Parity positions are still zero in w_place, so masking it covers data bits only.
    for (int unsigned j = 0; j < R; j++) begin
      w_mask = parity_mask(j);
      code_o[(1 << j) - 1] = ^(w_place & w_mask[n-1:0]);
    end
  end

endmodule

// File: rtl/h3_encode_stream_n_k.sv
// Streaming Hamming SEC encoder: valid/ready in and out, output reg plus skid reg,
// optional single-bit error injection and an accepted-word counter.
module h3_encode_stream_n_k
  import h3_encode_stream_n_k_pkg::*;
#(
  parameter int unsigned n     = 15,
  parameter int unsigned k     = 11,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [k-1:0]     data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic [n-1:0]     code_o,
  output logic             code_valid_o,
  input  logic             code_ready_i,
  output logic             code_inj_o,
  input  logic             inj_req_i,
  input  logic [3:0]       inj_pos_i,
  output logic             inj_armed_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  if (!legal_nk(n, k)) begin : g_illegal_nk
    $error("h3_encode_stream_n_k: illegal (n,k); use (15,11) or (7,4)");
  end

  logic [n-1:0]     w_enc;
  logic [n-1:0]     w_flip;
  logic [n-1:0]     w_code;
  logic             w_accept;
  logic             w_emit;
  logic             w_load;
  logic             w_pos_legal;

  logic [n-1:0]     r_out_code;
  logic             r_out_inj;
  logic             r_out_valid;
  logic [n-1:0]     r_skid_code;
  logic             r_skid_inj;
  logic             r_skid_valid;
  logic             r_armed;
  logic [3:0]       r_pos;
  logic [CNT_W-1:0] r_cnt;

  h3_encode_n_k #(
    .n (n),
    .k (k)
  ) u_enc (
    .data_i (data_i),
    .code_o (w_enc)
  );

  assign w_flip      = r_armed ? ({{(n-1){1'b0}}, 1'b1} << (r_pos - 4'd1)) : '0;
  assign w_code      = w_enc ^ w_flip;
  assign w_accept    = data_valid_i & ~r_skid_valid;
  assign w_emit      = r_out_valid & code_ready_i;
  assign w_load      = w_emit | ~r_out_valid;
  assign w_pos_legal = (inj_pos_i != 4'd0) && (32'(inj_pos_i) <= n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_code   <= '0;
      r_out_inj    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_code  <= '0;
      r_skid_inj   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_load) begin
      // Skid is only ever full while the output reg is full, so it drains first.
      if (r_skid_valid) begin
        r_out_code   <= r_skid_code;
        r_out_inj    <= r_skid_inj;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_code  <= w_code;
        r_out_inj   <= r_armed;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_code  <= w_code;
      r_skid_inj   <= r_armed;
      r_skid_valid <= 1'b1;
    end
  end

  // A request in the same cycle as an accept wins: the accepted word already used the old state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
      r_pos   <= 4'd0;
    end else if (inj_req_i) begin
      r_armed <= w_pos_legal;
      if (w_pos_legal) r_pos <= inj_pos_i;
    end else if (w_accept) begin
      r_armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign data_ready_o = ~r_skid_valid;
  assign code_o       = r_out_code;
  assign code_valid_o = r_out_valid;
  assign code_inj_o   = r_out_inj;
  assign inj_armed_o  = r_armed;
  assign word_cnt_o   = r_cnt;

endmodule

// File: tb/tb_h3_encode_stream_n_k.sv
// Bench for h3_encode_stream_n_k: occupancy/queue reference model plus a syndrome-based
// corrector model, directed literal vectors, back-pressure, injection, wrap and reset cases.
module tb_h3_encode_stream_n_k;

  localparam int unsigned N  = 15;
  localparam int unsigned K  = 11;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic [K-1:0]  data_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic [N-1:0]  code_o;
  logic          code_valid_o;
  logic          code_ready_i;
  logic          code_inj_o;
  logic          inj_req_i;
  logic [3:0]    inj_pos_i;
  logic          inj_armed_o;
  logic [CW-1:0] word_cnt_o;

  logic [3:0]    s7_data;
  logic          s7_valid;
  logic          s7_ready;
  logic [6:0]    s7_code;
  logic          s7_cvalid;
  logic          s7_inj;
  logic          s7_armed;
  logic [CW-1:0] s7_cnt;

  h3_encode_stream_n_k #(.n(N), .k(K), .CNT_W(CW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (code_ready_i),
    .code_inj_o   (code_inj_o),
    .inj_req_i    (inj_req_i),
    .inj_pos_i    (inj_pos_i),
    .inj_armed_o  (inj_armed_o),
    .word_cnt_o   (word_cnt_o)
  );

  h3_encode_stream_n_k #(.n(7), .k(4), .CNT_W(CW)) u_dut7 (
    .clk          (clk),
    .rst          (rst),
    .data_i       (s7_data),
    .data_valid_i (s7_valid),
    .data_ready_o (s7_ready),
    .code_o       (s7_code),
    .code_valid_o (s7_cvalid),
    .code_ready_i (1'b1),
    .code_inj_o   (s7_inj),
    .inj_req_i    (1'b0),
    .inj_pos_i    (4'd0),
    .inj_armed_o  (s7_armed),
    .word_cnt_o   (s7_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: data in non-power-of-two positions, parity bits spell the XOR of set data positions.
  function automatic logic [14:0] m_enc(input logic [10:0] d);
    logic [14:0] c;
    int s;
    int di;
    c  = '0;
    s  = 0;
    di = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[di];
        if (d[di]) s = s ^ p;
        di++;
      end
    end
    for (int j = 0; j < 4; j++) c[(1 << j) - 1] = s[j];
    return c;
  endfunction

  // Corrector: syndrome = XOR of set positions; flip it if nonzero, then extract data.
  task automatic m_dec(input logic [14:0] c, output logic [10:0] d, output logic sec);
    logic [14:0] cc;
    int s;
    int di;
    cc = c;
    s  = 0;
    for (int p = 1; p <= 15; p++) if (cc[p-1]) s = s ^ p;
    sec = (s != 0);
    if (s != 0) cc[s-1] = ~cc[s-1];
    d  = '0;
    di = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = cc[p-1];
        di++;
      end
    end
  endtask

  typedef struct {
    logic [10:0] data;
    logic [14:0] code;
    logic        inj;
  } ent_t;

  ent_t q[$];
  bit   m_armed = 1'b0;
  int   m_pos   = 0;
  int   m_cnt   = 0;
  int   m_total = 0;
  bit   chk_en  = 1'b0;

  // Inputs change at posedge+1, so at negedge they are what the next posedge will sample.
  always @(negedge clk) begin
    bit          acc;
    bit          em;
    logic [10:0] dd;
    logic        sec;
    ent_t        e;
    if (chk_en) begin
      if (rst) begin
        q.delete();
        m_armed = 1'b0;
        m_cnt   = 0;
        check("rst_ready", data_ready_o, 1);
        check("rst_valid", code_valid_o, 0);
        check("rst_code", code_o, 0);
        check("rst_inj", code_inj_o, 0);
        check("rst_armed", inj_armed_o, 0);
        check("rst_cnt", word_cnt_o, 0);
      end else begin
        check("ready", data_ready_o, (q.size() < 2));
        check("valid", code_valid_o, (q.size() > 0));
        check("armed", inj_armed_o, m_armed);
        check("cnt", word_cnt_o, m_cnt % (1 << CW));
        if (q.size() > 0) begin
          check("code", code_o, q[0].code);
          check("code_inj", code_inj_o, q[0].inj);
        end
        em  = (q.size() > 0) && code_ready_i;
        acc = data_valid_i && (q.size() < 2);
        if (em) begin
          m_dec(code_o, dd, sec);
          check("corr_sec", sec, q[0].inj);
          check("corr_data", dd, q[0].data);
          void'(q.pop_front());
        end
        if (acc) begin
          e.data = data_i;
          e.code = m_enc(data_i) ^ (m_armed ? (15'(1) << (m_pos - 1)) : 15'(0));
          e.inj  = m_armed;
          q.push_back(e);
          m_cnt++;
          m_total++;
        end
        if (inj_req_i) begin
          if (inj_pos_i >= 4'd1 && 32'(inj_pos_i) <= N) begin
            m_armed = 1'b1;
            m_pos   = int'(inj_pos_i);
          end else begin
            m_armed = 1'b0;
          end
        end else if (acc) begin
          m_armed = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lit(input logic [10:0] d, input logic [14:0] exp, input logic exp_inj,
                          input string nm);
    data_i       = d;
    data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    @(negedge clk);
    check(nm, code_o, exp);
    check({nm, "_inj"}, code_inj_o, exp_inj);
    check({nm, "_valid"}, code_valid_o, 1);
    tick();
  endtask

  initial begin
    int  sent;
    int  cyc;
    int  start;
    bit  rdy;
    data_i       = '0;
    data_valid_i = 1'b0;
    code_ready_i = 1'b0;
    inj_req_i    = 1'b0;
    inj_pos_i    = 4'd0;
    s7_data      = 4'd0;
    s7_valid     = 1'b0;
    rst          = 1'b1;
    chk_en       = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    check("model_001", m_enc(11'h001), 15'h0007);
    check("model_7ff", m_enc(11'h7FF), 15'h7FFF);
    check("model_400", m_enc(11'h400), 15'h408B);

    code_ready_i = 1'b1;
    send_lit(11'h001, 15'h0007, 1'b0, "lit_001");
    send_lit(11'h7FF, 15'h7FFF, 1'b0, "lit_7ff");
    send_lit(11'h400, 15'h408B, 1'b0, "lit_400");

    s7_data  = 4'h1;
    s7_valid = 1'b1;
    tick();
    s7_valid = 1'b0;
    @(negedge clk);
    check("n7_1", s7_code, 7'h07);
    tick();
    s7_data  = 4'hF;
    s7_valid = 1'b1;
    tick();
    s7_valid = 1'b0;
    @(negedge clk);
    check("n7_f", s7_code, 7'h7F);
    tick();

    // Injection: arm pos 5, flipped word, clean follow-up, then arm-and-disarm.
    inj_req_i = 1'b1;
    inj_pos_i = 4'd5;
    tick();
    inj_req_i = 1'b0;
    check("inj_armed", inj_armed_o, 1);
    send_lit(11'h000, 15'h0010, 1'b1, "inj_pos5");
    check("inj_cleared", inj_armed_o, 0);
    send_lit(11'h000, 15'h0000, 1'b0, "inj_clean");
    inj_req_i = 1'b1;
    inj_pos_i = 4'd5;
    tick();
    inj_pos_i = 4'd0;
    tick();
    inj_req_i = 1'b0;
    check("inj_disarm", inj_armed_o, 0);
    send_lit(11'h000, 15'h0000, 1'b0, "inj_disarmed");

    // Counter wrap with CNT_W=4.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    data_valid_i = 1'b1;
    repeat (17) begin
      data_i = 11'($urandom);
      tick();
    end
    data_valid_i = 1'b0;
    check("cnt_wrap17", word_cnt_o, 1);
    repeat (2) tick();

    // Back-pressure: 4 stalled cycles, then streaming.
    code_ready_i = 1'b0;
    data_valid_i = 1'b1;
    data_i       = 11'h123;
    tick();
    data_i = 11'h456;
    tick();
    check("bp_ready_low", data_ready_o, 0);
    data_i = 11'h789;
    repeat (2) tick();
    code_ready_i = 1'b1;
    sent = 0;
    cyc  = 0;
    while (sent < 8 && cyc < 100) begin
      rdy = data_ready_o;
      tick();
      cyc++;
      if (rdy) begin
        sent++;
        data_i = 11'($urandom);
      end
    end
    check("bp_stream_done", sent, 8);
    data_valid_i = 1'b0;
    repeat (3) tick();
    check("bp_drained", code_valid_o, 0);
    check("bp_ready_back", data_ready_o, 1);

    // Reset with two words buffered and injection armed.
    inj_req_i = 1'b1;
    inj_pos_i = 4'd3;
    tick();
    inj_req_i    = 1'b0;
    code_ready_i = 1'b0;
    data_valid_i = 1'b1;
    data_i       = 11'($urandom);
    tick();
    data_i = 11'($urandom);
    tick();
    data_valid_i = 1'b0;
    inj_req_i    = 1'b1;
    inj_pos_i    = 4'd7;
    tick();
    inj_req_i = 1'b0;
    check("pre_rst_ready", data_ready_o, 0);
    check("pre_rst_valid", code_valid_o, 1);
    check("pre_rst_armed", inj_armed_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", data_ready_o, 1);
    check("arst_valid", code_valid_o, 0);
    check("arst_code", code_o, 0);
    check("arst_inj", code_inj_o, 0);
    check("arst_armed", inj_armed_o, 0);
    check("arst_cnt", word_cnt_o, 0);
    tick();
    rst          = 1'b0;
    code_ready_i = 1'b1;

    // Random traffic with random back-pressure and injection requests.
    start = m_total;
    cyc   = 0;
    while ((m_total - start) < 10000 && cyc < 60000) begin
      data_valid_i = ($urandom_range(0, 3) != 0);
      data_i       = 11'($urandom);
      code_ready_i = ($urandom_range(0, 3) != 0);
      inj_req_i    = ($urandom_range(0, 15) == 0);
      inj_pos_i    = 4'($urandom);
      tick();
      cyc++;
    end
    check("random_words", ((m_total - start) >= 10000), 1);
    data_valid_i = 1'b0;
    inj_req_i    = 1'b0;
    code_ready_i = 1'b1;
    repeat (4) tick();
    check("final_empty", code_valid_o, 0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
